// File: rtl/id_pkg.sv
// id_pkg: shared encodings and the decoded-instruction record carried by the decode stage.
package id_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  typedef enum logic [1:0] {
    IMM_I  = 2'b00,
    IMM_SH = 2'b01,
    IMM_S  = 2'b10,
    IMM_U  = 2'b11
  } imm_type_e;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    imm_type_e       imm_type;
    logic            use_imm;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            word_op;
    logic            illegal;
  } dec_ctrl_t;
endpackage

// File: rtl/id_ctrl_dec.sv
// id_ctrl_dec: combinational opcode decode; pc and imm are left zero for the caller to fill.
module id_ctrl_dec
  import id_pkg::*;
(
  input  logic [24:0] inst_i,
  output dec_ctrl_t   ctrl_o
);
  logic [2:0] funct3;
  logic       is_shift;
  assign funct3   = inst_i[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  always_comb begin
    ctrl_o     = '0;
    ctrl_o.rs1 = inst_i[19:15];
    ctrl_o.rs2 = inst_i[24:20];
    ctrl_o.rd  = inst_i[11:7];
    case (inst_i[6:0])
      OPC_OP_IMM, OPC_OP_IMM32: begin
        ctrl_o.imm_type  = is_shift ? IMM_SH : IMM_I;
        ctrl_o.use_imm   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.word_op   = inst_i[6:0] == OPC_OP_IMM32;
      end
      OPC_OP, OPC_OP32: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.word_op   = inst_i[6:0] == OPC_OP32;
      end
      OPC_LOAD: begin
        ctrl_o.use_imm   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.mem_read  = 1'b1;
      end
      OPC_STORE: begin
        ctrl_o.imm_type  = IMM_S;
        ctrl_o.use_imm   = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      OPC_LUI: begin
        ctrl_o.imm_type  = IMM_U;
        ctrl_o.use_imm   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      default: ctrl_o.illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/imme.sv
// imme: immediate generator for the I, shift-amount, S and U formats.
module imme
  import id_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int INST_WIDTH   = 32,
  parameter int IMM_TYPE_NUM = 4
) (
  input  logic [INST_WIDTH-1:7]           inst_i,
  input  logic [$clog2(IMM_TYPE_NUM)-1:0] sel_i,
  output logic [DATA_WIDTH-1:0]           imm_o
);
  logic [DATA_WIDTH-1:0] imm_i, imm_sh, imm_s, imm_u;
  assign imm_i  = {{(DATA_WIDTH-12){inst_i[31]}}, inst_i[31:20]};
  assign imm_sh = {{(DATA_WIDTH-6){1'b0}}, inst_i[25:20]};
  assign imm_s  = {{(DATA_WIDTH-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_u  = {{(DATA_WIDTH-32){inst_i[31]}}, inst_i[31:12], 12'b0};
  always_comb begin
    imm_o = sel_i == IMM_SH ? imm_sh :
            sel_i == IMM_S  ? imm_s  :
            sel_i == IMM_U  ? imm_u  : imm_i;
  end
endmodule

// File: rtl/id_decode_stage.sv
// id_decode_stage: registered decode stage with an output register and a one-entry skid buffer.
module id_decode_stage
  import id_pkg::*;
#(
  parameter int DATA_WIDTH   = XLEN,
  parameter int INST_WIDTH   = ILEN,
  parameter int IMM_TYPE_NUM = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INST_WIDTH-1:0] in_inst,
  input  logic [DATA_WIDTH-1:0] in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [4:0]            out_rs1,
  output logic [4:0]            out_rs2,
  output logic [4:0]            out_rd,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic [1:0]            out_imm_type,
  output logic                  out_use_imm,
  output logic                  out_reg_write,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic                  out_word_op,
  output logic                  out_illegal
);
  dec_ctrl_t             ctrl, dec, o_q, o_d, s_q, s_d;
  logic                  o_valid_q, o_valid_d, s_valid_q, s_valid_d;
  logic                  acc, o_free;
  logic [DATA_WIDTH-1:0] imm;
  id_ctrl_dec u_dec (
    .inst_i(in_inst[24:0]),
    .ctrl_o(ctrl)
  );
  imme #(
    .DATA_WIDTH  (DATA_WIDTH),
    .INST_WIDTH  (INST_WIDTH),
    .IMM_TYPE_NUM(IMM_TYPE_NUM)
  ) u_imme (
    .inst_i(in_inst[INST_WIDTH-1:7]),
    .sel_i (ctrl.imm_type),
    .imm_o (imm)
  );
  always_comb begin
    dec     = ctrl;
    dec.pc  = in_pc;
    dec.imm = imm;
  end
  // O is free when empty or draining; S only fills while O is stalled.
  always_comb begin
    acc       = in_valid && !s_valid_q;
    o_free    = !o_valid_q || out_ready;
    o_valid_d = flush ? 1'b0 : o_free ? (s_valid_q || acc) : 1'b1;
    s_valid_d = flush ? 1'b0 : o_free ? 1'b0 : (s_valid_q || acc);
    o_d       = o_free && s_valid_q ? s_q : o_free && acc ? dec : o_q;
    s_d       = !o_free && acc ? dec : s_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      o_q       <= '0;
      s_q       <= '0;
    end else begin
      o_valid_q <= o_valid_d;
      s_valid_q <= s_valid_d;
      o_q       <= o_d;
      s_q       <= s_d;
    end
  end
  assign in_ready      = !s_valid_q;
  assign out_valid     = o_valid_q;
  assign out_pc        = o_q.pc;
  assign out_rs1       = o_q.rs1;
  assign out_rs2       = o_q.rs2;
  assign out_rd        = o_q.rd;
  assign out_imm       = o_q.imm;
  assign out_imm_type  = o_q.imm_type;
  assign out_use_imm   = o_q.use_imm;
  assign out_reg_write = o_q.reg_write;
  assign out_mem_read  = o_q.mem_read;
  assign out_mem_write = o_q.mem_write;
  assign out_word_op   = o_q.word_op;
  assign out_illegal   = o_q.illegal;
endmodule

// File: doc/id_decode_stage.md
Name: id_decode_stage

Overview:
- Registered instruction-decode pipeline stage, between instruction fetch and execute.
- Accepts one 32-bit instruction plus PC per cycle over a valid/ready handshake.
- Decodes control fields and the 2-bit immediate-type select, generates the 64-bit immediate, and presents the result in a pipeline register.
- A one-entry skid register sustains full throughput under downstream backpressure; flush support covers branch/exception redirects.

Parameters:
- DATA_WIDTH, 64, width of the immediate and PC.
- INST_WIDTH, 32, instruction width.
- IMM_TYPE_NUM, 4, number of immediate formats; the select is $clog2(IMM_TYPE_NUM) bits wide.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all held and incoming instructions this cycle.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept (= skid register empty).
- in_inst  in  INST_WIDTH  instruction word.
- in_pc  in  DATA_WIDTH  instruction address.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  execute accepts.
- out_pc  out  DATA_WIDTH  passed-through PC.
- out_rs1, out_rs2, out_rd  out  5 each  inst[19:15], inst[24:20], inst[11:7].
- out_imm  out  DATA_WIDTH  generated immediate.
- out_imm_type  out  2  00 I-type, 01 shift-amount, 10 S-type, 11 U-type (LUI).
- out_use_imm  out  1  ALU operand B is the immediate.
- out_reg_write  out  1  writes rd.
- out_mem_read  out  1  load.
- out_mem_write  out  1  store.
- out_word_op  out  1  *W (32-bit) opcode.
- out_illegal  out  1  opcode unsupported.

Behaviour:
- Reset (rst=1 at an edge): out_valid=0, skid empty, every out_* data field 0, in_ready=1 the following cycle. Reset mid-transfer drops all in-flight instructions; no partial output.
- Decode is combinational on in_inst; the result is captured on accept (in_valid && in_ready). Latency is one cycle, input accept to out_valid.
- Opcode map:
  - 0010011 OP-IMM: funct3 001/101 → imm_type 01, otherwise 00; use_imm=1, reg_write=1.
  - 0011011 OP-IMM-32: as OP-IMM, plus word_op=1.
  - 0110011 OP: use_imm=0, imm_type 00, reg_write=1.
  - 0111011 OP-32: as OP, plus word_op=1.
  - 0000011 LOAD: imm_type 00, use_imm=1, reg_write=1, mem_read=1.
  - 0100011 STORE: imm_type 10, use_imm=1, mem_write=1, reg_write=0.
  - 0110111 LUI: imm_type 11, use_imm=1, reg_write=1.
  - Any other opcode: illegal=1, reg_write=mem_read=mem_write=0, imm_type 00. The instruction still flows to out so execute can raise the exception.
- Immediate formats:
  - 00: sign-extended inst[31:20].
  - 01: zero-extended inst[25:20] (6-bit shamt for RV64; OP-IMM-32 uses inst[24:20] with inst[25]=0).
  - 10: sign-extended {inst[31:25], inst[11:7]}.
  - 11: sign-extended {inst[31:12], 12'b0}.
- Handshake, output register (O) plus skid register (S):
  - in_ready = !S.valid.
  - Output transfer occurs when out_valid && out_ready.
  - O empty, or O transferring this cycle: O loads from S if S.valid, else from the input if accepted.
  - O held (out_valid && !out_ready) and input accepted: the input goes to S.
  - Order is strictly preserved. No instruction is duplicated or lost while out_ready toggles.
- Full-throughput: with out_ready tied high, one instruction is accepted and emitted per cycle.
- Output fields remain stable while out_valid && !out_ready.
- flush=1: O.valid and S.valid clear at the edge; an instruction offered the same cycle is dropped even if in_ready=1. in_ready=1 the next cycle. flush takes priority over every accept/transfer. rst takes priority over flush.

Decomposition:
- Package id_pkg: imm_type encoding constants (IMM_I, IMM_SH, IMM_S, IMM_U), opcode localparams, and a packed struct dec_ctrl_t containing pc, rs1, rs2, rd, imm, imm_type, and the control bits, used for both O and S.
- Sub-modules:
  - Combinational decoder id_ctrl_dec (inst → dec_ctrl_t minus imm).
  - The team's imme immediate generator, instantiated with the decoded imm_type, implementing the formats above.

Test Plan:
- Reset then 0x00500093 (addi x1,x0,5), pc=0x1000 → next cycle out_valid=1, rd=1, rs1=0, imm=5, imm_type=00, use_imm=1, reg_write=1.
- 0x0020A423 (sw x2,8(x1)) → imm=8, imm_type=10, rs1=1, rs2=2, mem_write=1, reg_write=0. Also 0xFE20AE23 (sw x2,-4(x1)) → imm=0xFFFF_FFFF_FFFF_FFFC.
- 0x123452B7 (lui x5,0x12345) → imm=0x0000_0000_1234_5000, imm_type=11, rd=5. Also 0x03F0D093 (srli x1,x1,63) → imm_type=01, imm=63.
- Stream of 6 addi with out_ready pattern 1,0,0,1,0,1,1,1 → all 6 emitted in order, none duplicated; in_ready falls only while S is full; outputs stable while stalled.
- Fill O and S (out_ready=0), assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1; the flushed and offered instructions never appear.
- Opcode 0x7F word 0x0000007F → out_illegal=1, reg_write=0. rst asserted while O and S are full → out_valid=0, all data fields 0 next cycle.
